rf_writeback_queue: RTL and testbench

//  Write-side front end for the 32x32 register file; it owns the single RF write port.

---
 rtl/rf_writeback_queue.sv | 126 ++++++++++++
 tb/tb_rf_writeback_queue.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_queue.sv
// In-order writeback FIFO that owns the single RF write port and offers decode a
// pending-write lookup (youngest FIFO entry first, then the rf_* stage).
module rf_writeback_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32,
   parameter int AW    = 5,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [AW-1:0]   in_rd,
   input  logic [XLEN-1:0] in_data,
   input  logic            wb_en,
   input  logic            flush,
   output logic            rf_we,
   output logic [AW-1:0]   rf_rd,
   output logic [XLEN-1:0] rf_wdata,
   input  logic [AW-1:0]   q_rs1,
   input  logic [AW-1:0]   q_rs2,
   output logic            q_hit1,
   output logic            q_hit2,
   output logic [XLEN-1:0] q_fwd1,
   output logic [XLEN-1:0] q_fwd2,
   output logic [CW-1:0]   count
);

   logic [AW-1:0]   mem_rd_q   [DEPTH];
   logic [AW-1:0]   mem_rd_d   [DEPTH];
   logic [XLEN-1:0] mem_data_q [DEPTH];
   logic [XLEN-1:0] mem_data_d [DEPTH];
   logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic            rf_we_q, rf_we_d;
   logic [AW-1:0]   rf_rd_q, rf_rd_d;
   logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
   logic            push, pop;

   assign in_ready = (count_q != CW'(DEPTH));
   assign count    = count_q;
   assign rf_we    = rf_we_q;
   assign rf_rd    = rf_rd_q;
   assign rf_wdata = rf_wdata_q;

   // x0 results complete the handshake but are never stored
   assign push = in_valid && in_ready && (in_rd != '0);
   assign pop  = wb_en && (count_q != '0);

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      mem_rd_d   = mem_rd_q;
      mem_data_d = mem_data_q;
      rf_we_d    = 1'b0;
      rf_rd_d    = rf_rd_q;
      rf_wdata_d = rf_wdata_q;
      if (flush) begin
         count_d = '0;
         head_d  = tail_q;
      end else begin
         if (pop) begin
            rf_we_d    = 1'b1;
            rf_rd_d    = mem_rd_q[head_q];
            rf_wdata_d = mem_data_q[head_q];
            head_d     = head_q + PW'(1);
         end
         if (push) begin
            mem_rd_d[tail_q]   = in_rd;
            mem_data_d[tail_q] = in_data;
            tail_d             = tail_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Scan oldest to youngest so the youngest match overwrites earlier ones
   function automatic logic [XLEN:0] lookup(input logic [AW-1:0] rs);
      logic [XLEN:0] res;
      logic [PW-1:0] idx;
      res = '0;
      if (rf_we_q && (rf_rd_q == rs)) res = {1'b1, rf_wdata_q};
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx = head_q + PW'(k);
         if ((CW'(k) < count_q) && (mem_rd_q[idx] == rs)) res = {1'b1, mem_data_q[idx]};
      end
      if (rs == '0) res = '0;
      return res;
   endfunction

   always_comb begin
      {q_hit1, q_fwd1} = lookup(q_rs1);
      {q_hit2, q_fwd2} = lookup(q_rs2);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         rf_we_q    <= 1'b0;
         rf_rd_q    <= '0;
         rf_wdata_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_rd_q[i]   <= '0;
            mem_data_q[i] <= '0;
         end
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         rf_we_q    <= rf_we_d;
         rf_rd_q    <= rf_rd_d;
         rf_wdata_q <= rf_wdata_d;
         mem_rd_q   <= mem_rd_d;
         mem_data_q <= mem_data_d;
      end
   end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed and random checks of rf_writeback_queue against a queue-based model of
// the writeback/lookup rules.
module tb_rf_writeback_queue;
   localparam int DEPTH = 4;
   localparam int XLEN  = 32;
   localparam int AW    = 5;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid, in_ready;
   logic [AW-1:0]   in_rd;
   logic [XLEN-1:0] in_data;
   logic            wb_en, flush;
   logic            rf_we;
   logic [AW-1:0]   rf_rd;
   logic [XLEN-1:0] rf_wdata;
   logic [AW-1:0]   q_rs1, q_rs2;
   logic            q_hit1, q_hit2;
   logic [XLEN-1:0] q_fwd1, q_fwd2;
   logic [CW-1:0]   count;

   int vectors = 0;
   int miscompares = 0;

   rf_writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_rd(in_rd), .in_data(in_data), .wb_en(wb_en), .flush(flush),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
      .q_rs1(q_rs1), .q_rs2(q_rs2), .q_hit1(q_hit1), .q_hit2(q_hit2),
      .q_fwd1(q_fwd1), .q_fwd2(q_fwd2), .count(count)
   );

   always #5 clk = ~clk;

   // Reference model: pending results in arrival order plus the write-port stage
   logic [AW+XLEN-1:0] mq[$];
   logic            m_we;
   logic [AW-1:0]   m_rd;
   logic [XLEN-1:0] m_wdata;

   task automatic model_reset();
      mq.delete();
      m_we = 1'b0; m_rd = '0; m_wdata = '0;
   endtask

   function automatic logic [XLEN:0] mlook(input logic [AW-1:0] rs);
      if (rs == 0) return '0;
      for (int i = mq.size() - 1; i >= 0; i--)
         if (mq[i][AW+XLEN-1:XLEN] == rs) return {1'b1, mq[i][XLEN-1:0]};
      if (m_we && m_rd == rs) return {1'b1, m_wdata};
      return '0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [XLEN:0] l1, l2;
      l1 = mlook(q_rs1);
      l2 = mlook(q_rs2);
      chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      chk("count", 32'(count), 32'(mq.size()));
      chk("rf_we", 32'(rf_we), 32'(m_we));
      chk("rf_rd", 32'(rf_rd), 32'(m_rd));
      chk("rf_wdata", rf_wdata, m_wdata);
      chk("q_hit1", 32'(q_hit1), 32'(l1[XLEN]));
      chk("q_fwd1", q_fwd1, l1[XLEN-1:0]);
      chk("q_hit2", 32'(q_hit2), 32'(l2[XLEN]));
      chk("q_fwd2", q_fwd2, l2[XLEN-1:0]);
   endtask

   // Called at a negedge: drive, check pre-edge state, advance DUT and model one edge
   task automatic cycle(input logic vi, input logic [AW-1:0] rd, input logic [XLEN-1:0] d,
                        input logic wb, input logic fl,
                        input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
      logic rdy;
      logic [AW+XLEN-1:0] e;
      in_valid = vi; in_rd = rd; in_data = d; wb_en = wb; flush = fl;
      q_rs1 = rs1; q_rs2 = rs2;
      #1;
      check_all();
      @(posedge clk);
      rdy = (mq.size() < DEPTH);
      if (fl) begin
         mq.delete();
         m_we = 1'b0;
      end else begin
         if (wb && mq.size() != 0) begin
            e = mq.pop_front();
            m_rd = e[AW+XLEN-1:XLEN];
            m_wdata = e[XLEN-1:0];
            m_we = 1'b1;
         end else m_we = 1'b0;
         if (vi && rdy && rd != 0) mq.push_back({rd, d});
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic wb, input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, wb, 1'b0, 5'd1, 5'd2);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 0; in_rd = '0; in_data = '0; wb_en = 0; flush = 0;
      q_rs1 = '0; q_rs2 = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_count", 32'(count), 0);
      chk("rst_rf_we", 32'(rf_we), 0);
      chk("rst_rf_rd", 32'(rf_rd), 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      rst_n = 1'b1;

      // single push, visible on the write port one cycle after the push edge
      cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 5'd5, 5'd0);
      chk("lat_cnt", 32'(count), 1);
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 5'd5, 5'd0);
      chk("lat_we", 32'(rf_we), 1);
      chk("lat_rd", 32'(rf_rd), 5);
      chk("lat_data", rf_wdata, 32'hDEADBEEF);
      idle(1'b1, 2);

      // fill with drain frozen, then drain in order
      for (int i = 1; i <= 5; i++) cycle(1'b1, AW'(i), 32'(i * 16), 1'b0, 1'b0, 5'd3, 5'd5);
      chk("full_cnt", 32'(count), 4);
      chk("full_rdy", 32'(in_ready), 0);
      for (int i = 1; i <= 4; i++) begin
         cycle(1'b0, '0, '0, 1'b1, 1'b0, 5'd4, 5'd1);
         chk("drain_we", 32'(rf_we), 1);
         chk("drain_rd", 32'(rf_rd), 32'(i));
      end
      chk("drain_cnt", 32'(count), 0);
      idle(1'b1, 1);

      // youngest pending value wins; x0 lookup never hits
      cycle(1'b1, 5'd7, 32'h11, 1'b0, 1'b0, 5'd7, 5'd0);
      cycle(1'b1, 5'd7, 32'h22, 1'b0, 1'b0, 5'd7, 5'd0);
      q_rs1 = 5'd7; q_rs2 = 5'd0; #1;
      chk("fwd_hit1", 32'(q_hit1), 1);
      chk("fwd_val1", q_fwd1, 32'h22);
      chk("fwd_hit2", 32'(q_hit2), 0);
      chk("fwd_val2", q_fwd2, 0);
      idle(1'b1, 4);

      // x0 writes are consumed but dropped
      cycle(1'b1, 5'd0, 32'hFF, 1'b1, 1'b0, 5'd0, 5'd0);
      chk("x0_cnt", 32'(count), 0);
      idle(1'b1, 1);
      chk("x0_we", 32'(rf_we), 0);

      // flush beats push and pop on a full queue
      for (int i = 1; i <= 4; i++) cycle(1'b1, AW'(i + 8), 32'(i), 1'b0, 1'b0, 5'd9, 5'd12);
      cycle(1'b1, 5'd20, 32'h55, 1'b1, 1'b1, 5'd9, 5'd20);
      chk("flush_cnt", 32'(count), 0);
      chk("flush_we", 32'(rf_we), 0);
      idle(1'b1, 1);
      chk("flush_after_we", 32'(rf_we), 0);

      // wrap: back-to-back push/pop keeps order
      for (int i = 1; i <= 10; i++) begin
         cycle(1'b1, AW'(i), 32'(i + 100), 1'b1, 1'b0, AW'(i), 5'd3);
         if (i >= 2) chk("wrap_rd", 32'(rf_rd), 32'(i - 1));
      end
      idle(1'b1, 1);
      chk("wrap_last", 32'(rf_rd), 10);

      // reset mid-stream with three entries queued
      for (int i = 1; i <= 3; i++) cycle(1'b1, AW'(i + 20), 32'(i), 1'b0, 1'b0, 5'd21, 5'd0);
      rst_n = 1'b0; #1;
      chk("mrst_cnt", 32'(count), 0);
      chk("mrst_we", 32'(rf_we), 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      idle(1'b1, 3);
      chk("mrst_after_we", 32'(rf_we), 0);

      // random traffic against the model
      for (int n = 0; n < 400; n++)
         cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
               AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      idle(1'b1, 6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
